otter_pc_unit: RTL and testbench
================================

Name: otter_pc_unit

Overview:
Parametrised program-counter unit for the OTTER MCU. It holds the PC register, generates PC+INC, and selects the next PC from six sources. It raises a one-cycle redirect pulse for front-end flush and keeps a saturating redirect performance counter. It sits between the control FSM/branch logic and instruction memory, and replaces the fixed-width, increment-only PC path.

Parameters:
XLEN, 32, width of PC and all address inputs/outputs (min 8)
INC, 4, increment added for sequential fetch (power of two, < 2**XLEN)
RESET_VEC, 32'h0000_0000, PC value loaded on reset (XLEN bits)
CNT_W, 16, width of redirect performance counter

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  synchronous, active-high reset
PC_WRITE  in  1  commit enable for the PC register
PC_SOURCE  in  3  next-PC select (pc_src_t)
JALR  in  XLEN  jalr target
BRANCH  in  XLEN  branch target
JAL  in  XLEN  jal target
MTVEC  in  XLEN  trap vector
MEPC  in  XLEN  trap return address
CNT_CLR  in  1  clear redirect counter
PC_COUNT  out  XLEN  current PC (registered)
PC_PLUS  out  XLEN  PC_COUNT + INC (combinational, wraps mod 2**XLEN)
REDIRECT  out  1  registered pulse: previous cycle committed a non-sequential PC
REDIRECT_CNT  out  CNT_W  saturating count of committed redirects
MISALIGN  out  1  misaligned-target pulse (0 when feature compiled out)
MISALIGN_ADDR  out  XLEN  captured offending target (0 when feature compiled out)

Behaviour:
- Reset (RST=1 at edge): PC_COUNT=RESET_VEC, REDIRECT=0, REDIRECT_CNT=0, MISALIGN=0, MISALIGN_ADDR=0. Reset dominates PC_WRITE and CNT_CLR. A reset mid-stream discards any pending update.
- Source decode: 0 SEQ -> PC_PLUS; 1 JALR -> {JALR[XLEN-1:1],1'b0}; 2 BRANCH; 3 JAL; 4 TRAP -> MTVEC; 5 MRET -> MEPC; 6,7 reserved -> next = PC_COUNT (hold), not a redirect.
- Update: PC_WRITE=1 at edge -> PC_COUNT <= next, 1-cycle latency. PC_WRITE=0 -> PC_COUNT holds, and no redirect or count activity occurs.
- REDIRECT <= PC_WRITE && source in 1..5 && update accepted. It is high exactly one cycle per committed redirect and asserts back-to-back on consecutive redirects.
- REDIRECT_CNT increments on every cycle REDIRECT is set and saturates at all-ones with no wrap.
- CNT_CLR=1 -> counter <= 0. Clear wins over a simultaneous increment.
- Wrap-around: PC_PLUS at PC_COUNT = 2**XLEN-INC yields 0; the PC register wraps silently.
- Register state: the only state is PC_COUNT, REDIRECT, REDIRECT_CNT, MISALIGN, MISALIGN_ADDR. There is no multi-cycle FSM; every update is single-cycle.

Optional Feature:
Macro: OTTER_PC_MISALIGN_CHECK_EN
- Defined:
  - Sources JALR/BRANCH/JAL/MRET with target[1:0] != 2'b00 (after the JALR bit-0 clear) and PC_WRITE=1 are rejected. PC_COUNT holds, REDIRECT stays 0, and the counter is unchanged.
  - MISALIGN pulses 1 on the next cycle, and MISALIGN_ADDR <= offending target (holds until the next rejection or reset).
  - TRAP (MTVEC) is never checked.
- Undefined: no check is made. Misaligned targets load as-is. MISALIGN and MISALIGN_ADDR are tied to 0.

Decomposition:
- Package otter_pc_pkg:
  - typedef enum logic [2:0] pc_src_t {PC_SRC_SEQ, PC_SRC_JALR, PC_SRC_BRANCH, PC_SRC_JAL, PC_SRC_TRAP, PC_SRC_MRET}
  - localparam PC_SRC_W=3
  - function is_redirect(pc_src_t)
- Sub-module pc_incrementer (params XLEN, INC): purely combinational PC_PLUS adder, reusable by fetch-stage prefetch logic.

Test Plan:
- RST=1 with RESET_VEC=0 -> PC_COUNT=0, REDIRECT=0, CNT=0. Then 3 cycles of PC_WRITE=1, SEQ -> PC_COUNT=4, 8, 0xC.
- PC=0x10, PC_WRITE=1, SRC=JALR, JALR=0x101 -> next PC=0x100, REDIRECT=1 for one cycle, CNT=1.
- PC_WRITE=0, SRC=BRANCH, BRANCH=0x40 for 2 cycles -> PC unchanged, REDIRECT=0, CNT unchanged.
- Preload CNT to all-ones-1 via redirects (CNT_W=4: 15 JALs) -> CNT saturates at 0xF. CNT_CLR coincident with a JAL -> CNT=0.
- PC=0xFFFF_FFFC, SEQ -> PC_COUNT=0. SRC=6 -> PC holds, REDIRECT=0.
- With OTTER_PC_MISALIGN_CHECK_EN: SRC=JAL, JAL=0x202 -> PC holds, MISALIGN=1 one cycle, MISALIGN_ADDR=0x202. Same stimulus without macro -> PC=0x202, MISALIGN=0.

Source files
------------

// File: rtl/otter_pc_pkg.sv
// Shared types and helpers for the OTTER program-counter unit.
// Optional misaligned-target rejection is enabled by defining OTTER_PC_MISALIGN_CHECK_EN.
package otter_pc_pkg;

    localparam int PC_SRC_W = 3;

    typedef enum logic [PC_SRC_W-1:0] {
        PC_SRC_SEQ    = 3'd0,
        PC_SRC_JALR   = 3'd1,
        PC_SRC_BRANCH = 3'd2,
        PC_SRC_JAL    = 3'd3,
        PC_SRC_TRAP   = 3'd4,
        PC_SRC_MRET   = 3'd5
    } pc_src_t;

    // Codes 6 and 7 are reserved; callers must screen them before casting to pc_src_t.
    function automatic logic src_is_defined(input logic [PC_SRC_W-1:0] raw);
        return (raw <= 3'd5);
    endfunction

    function automatic logic is_redirect(input pc_src_t src);
        logic r;
        case (src)
            PC_SRC_JALR, PC_SRC_BRANCH, PC_SRC_JAL,
            PC_SRC_TRAP, PC_SRC_MRET: r = 1'b1;
            default:                  r = 1'b0;
        endcase
        return r;
    endfunction

    // The trap vector is trusted and never checked for alignment.
    function automatic logic needs_align_check(input pc_src_t src);
        logic r;
        case (src)
            PC_SRC_JALR, PC_SRC_BRANCH,
            PC_SRC_JAL, PC_SRC_MRET: r = 1'b1;
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/otter_pc_unit_incrementer.sv
// Combinational sequential-fetch adder: pc_plus_o = pc_i + INC, wrapping mod 2**XLEN.
// Kept standalone so fetch-stage prefetch logic can reuse it.
module pc_incrementer #(
    parameter int XLEN = 32,
    parameter int INC  = 4
) (
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] pc_plus_o
);

    localparam logic [XLEN-1:0] INC_V = XLEN'(INC);

    assign pc_plus_o = pc_i + INC_V;

endmodule

// File: rtl/otter_pc_unit.sv
// OTTER program-counter unit: PC register, six-way next-PC select, redirect pulse and counter.
// Define OTTER_PC_MISALIGN_CHECK_EN to reject and report misaligned jump/branch/return targets.
module otter_pc_unit
    import otter_pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              INC       = 4,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              CNT_W     = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                PC_WRITE,
    input  logic [PC_SRC_W-1:0] PC_SOURCE,
    input  logic [XLEN-1:0]     JALR,
    input  logic [XLEN-1:0]     BRANCH,
    input  logic [XLEN-1:0]     JAL,
    input  logic [XLEN-1:0]     MTVEC,
    input  logic [XLEN-1:0]     MEPC,
    input  logic                CNT_CLR,
    output logic [XLEN-1:0]     PC_COUNT,
    output logic [XLEN-1:0]     PC_PLUS,
    output logic                REDIRECT,
    output logic [CNT_W-1:0]    REDIRECT_CNT,
    output logic                MISALIGN,
    output logic [XLEN-1:0]     MISALIGN_ADDR
);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pc_plus;
    logic [XLEN-1:0]  target;
    logic             src_known;
    logic             redirect_src;
    logic             reject;
    logic             accept;
    logic             redirect_q, redirect_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unused_jalr_lsb;

    assign unused_jalr_lsb = JALR[0];

    pc_incrementer #(
        .XLEN (XLEN),
        .INC  (INC)
    ) u_inc (
        .pc_i      (pc_q),
        .pc_plus_o (pc_plus)
    );

    always_comb begin
        target = pc_q;
        case (PC_SOURCE)
            PC_SRC_SEQ:    target = pc_plus;
            PC_SRC_JALR:   target = {JALR[XLEN-1:1], 1'b0};
            PC_SRC_BRANCH: target = BRANCH;
            PC_SRC_JAL:    target = JAL;
            PC_SRC_TRAP:   target = MTVEC;
            PC_SRC_MRET:   target = MEPC;
            default:       target = pc_q;
        endcase
    end

    assign src_known    = src_is_defined(PC_SOURCE);
    assign redirect_src = src_known && is_redirect(pc_src_t'(PC_SOURCE));

`ifdef OTTER_PC_MISALIGN_CHECK_EN
    logic            mis_q, mis_d;
    logic [XLEN-1:0] mis_addr_q, mis_addr_d;
    logic            chk_src;

    assign chk_src    = src_known && needs_align_check(pc_src_t'(PC_SOURCE));
    assign reject     = PC_WRITE && chk_src && (target[1:0] != 2'b00);
    assign mis_d      = reject;
    assign mis_addr_d = reject ? target : mis_addr_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
        end else begin
            mis_q      <= mis_d;
            mis_addr_q <= mis_addr_d;
        end
    end

    assign MISALIGN      = mis_q;
    assign MISALIGN_ADDR = mis_addr_q;
`else
    assign reject        = 1'b0;
    assign MISALIGN      = 1'b0;
    assign MISALIGN_ADDR = '0;
`endif

    assign accept     = PC_WRITE && !reject;
    assign pc_d       = accept ? target : pc_q;
    assign redirect_d = accept && redirect_src;

    // Clear beats a coincident increment; the counter sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (CNT_CLR) begin
            cnt_d = '0;
        end else if (redirect_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q       <= RESET_VEC;
            redirect_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            cnt_q      <= cnt_d;
        end
    end

    assign PC_COUNT     = pc_q;
    assign PC_PLUS      = pc_plus;
    assign REDIRECT     = redirect_q;
    assign REDIRECT_CNT = cnt_q;

endmodule

// File: tb/tb_otter_pc_unit.sv
// Directed self-checking bench for otter_pc_unit (XLEN=32, INC=4, RESET_VEC=0, CNT_W=4).
module tb_otter_pc_unit;

`ifdef OTTER_PC_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        PC_WRITE;
    logic [2:0]  PC_SOURCE;
    logic [31:0] JALR, BRANCH, JAL, MTVEC, MEPC;
    logic        CNT_CLR;
    logic [31:0] PC_COUNT, PC_PLUS, MISALIGN_ADDR;
    logic        REDIRECT, MISALIGN;
    logic [3:0]  REDIRECT_CNT;

    int total = 0;
    int bad   = 0;

    otter_pc_unit #(
        .XLEN      (32),
        .INC       (4),
        .RESET_VEC (32'h0000_0000),
        .CNT_W     (4)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .PC_WRITE      (PC_WRITE),
        .PC_SOURCE     (PC_SOURCE),
        .JALR          (JALR),
        .BRANCH        (BRANCH),
        .JAL           (JAL),
        .MTVEC         (MTVEC),
        .MEPC          (MEPC),
        .CNT_CLR       (CNT_CLR),
        .PC_COUNT      (PC_COUNT),
        .PC_PLUS       (PC_PLUS),
        .REDIRECT      (REDIRECT),
        .REDIRECT_CNT  (REDIRECT_CNT),
        .MISALIGN      (MISALIGN),
        .MISALIGN_ADDR (MISALIGN_ADDR)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic rd,
                               input logic [3:0] cnt);
        check({tag, "_pc"}, PC_COUNT, pc);
        check({tag, "_redir"}, 32'(REDIRECT), 32'(rd));
        check({tag, "_cnt"}, 32'(REDIRECT_CNT), 32'(cnt));
    endtask

    initial begin
        RST = 1'b1; PC_WRITE = 1'b0; PC_SOURCE = 3'd0; CNT_CLR = 1'b0;
        JALR = '0; BRANCH = '0; JAL = '0; MTVEC = '0; MEPC = '0;
        step();
        check_state("reset", 32'h0, 1'b0, 4'd0);
        check("reset_mis", 32'(MISALIGN), 32'h0);
        check("reset_misaddr", MISALIGN_ADDR, 32'h0);
        check("reset_plus", PC_PLUS, 32'h4);

        // Sequential fetch
        RST = 1'b0; PC_WRITE = 1'b1; PC_SOURCE = 3'd0;
        step(); check_state("seq1", 32'h4, 1'b0, 4'd0);
        step(); check_state("seq2", 32'h8, 1'b0, 4'd0);
        step(); check_state("seq3", 32'hC, 1'b0, 4'd0);
        step(); check_state("seq4", 32'h10, 1'b0, 4'd0);

        // JALR clears bit 0
        PC_SOURCE = 3'd1; JALR = 32'h101;
        step(); check_state("jalr", 32'h100, 1'b1, 4'd1);
        PC_SOURCE = 3'd0;
        step(); check_state("jalr_after", 32'h104, 1'b0, 4'd1);

        // Stalled: no commit, no redirect
        PC_WRITE = 1'b0; PC_SOURCE = 3'd2; BRANCH = 32'h40;
        step(); check_state("stall1", 32'h104, 1'b0, 4'd1);
        step(); check_state("stall2", 32'h104, 1'b0, 4'd1);

        // Back-to-back JALs up to saturation
        PC_WRITE = 1'b1; PC_SOURCE = 3'd3; JAL = 32'h200;
        for (int i = 0; i < 14; i++) begin
            step();
            check("b2b_redir", 32'(REDIRECT), 32'h1);
        end
        check_state("cnt_full", 32'h200, 1'b1, 4'hF);
        step(); check_state("cnt_sat", 32'h200, 1'b1, 4'hF);
        CNT_CLR = 1'b1;
        step(); check_state("cnt_clr", 32'h200, 1'b1, 4'h0);
        CNT_CLR = 1'b0;

        // Wrap-around of the PC
        JAL = 32'hFFFF_FFFC;
        step(); check_state("to_top", 32'hFFFF_FFFC, 1'b1, 4'd1);
        check("plus_wrap", PC_PLUS, 32'h0);
        PC_SOURCE = 3'd0;
        step(); check_state("wrap", 32'h0, 1'b0, 4'd1);

        // Reserved source holds
        PC_SOURCE = 3'd6; JAL = 32'h500;
        step(); check_state("rsvd6", 32'h0, 1'b0, 4'd1);
        PC_SOURCE = 3'd7;
        step(); check_state("rsvd7", 32'h0, 1'b0, 4'd1);

        // Misaligned JAL target
        PC_SOURCE = 3'd3; JAL = 32'h202;
        step();
        check_state("mis_jal", MIS_EN ? 32'h0 : 32'h202, !MIS_EN, MIS_EN ? 4'd1 : 4'd2);
        check("mis_pulse", 32'(MISALIGN), MIS_EN ? 32'h1 : 32'h0);
        check("mis_addr", MISALIGN_ADDR, MIS_EN ? 32'h202 : 32'h0);

        // Trap vector is never alignment-checked
        PC_SOURCE = 3'd4; MTVEC = 32'h302;
        step();
        check_state("trap", 32'h302, 1'b1, MIS_EN ? 4'd2 : 4'd3);
        check("trap_mis", 32'(MISALIGN), 32'h0);
        check("trap_misaddr", MISALIGN_ADDR, MIS_EN ? 32'h202 : 32'h0);

        PC_SOURCE = 3'd5; MEPC = 32'h80;
        step(); check_state("mret", 32'h80, 1'b1, MIS_EN ? 4'd3 : 4'd4);

        // Reset mid-stream discards the pending JAL
        PC_SOURCE = 3'd3; JAL = 32'h400; RST = 1'b1; CNT_CLR = 1'b0;
        step();
        check_state("rst_mid", 32'h0, 1'b0, 4'd0);
        check("rst_mid_misaddr", MISALIGN_ADDR, 32'h0);
        RST = 1'b0; PC_WRITE = 1'b0;
        step(); check_state("post_rst", 32'h0, 1'b0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
